// File: rtl/param_reg_file_if.sv
// Register-file access bundle: one write port, two read ports,
// clear request and status.
interface param_reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              write;
    logic [ADDR_W-1:0] Adr_register_to_save;
    logic [DATA_W-1:0] data_from_ctrl;
    logic [ADDR_W-1:0] Adr_register_to_A;
    logic [ADDR_W-1:0] Adr_register_to_B;
    logic              clear_req;
    logic [DATA_W-1:0] data_to_A;
    logic [DATA_W-1:0] data_to_B;
    logic              busy;
    logic              wr_err;

    modport master (
        output write,
        output Adr_register_to_save,
        output data_from_ctrl,
        output Adr_register_to_A,
        output Adr_register_to_B,
        output clear_req,
        input  data_to_A,
        input  data_to_B,
        input  busy,
        input  wr_err
    );

    modport slave (
        input  write,
        input  Adr_register_to_save,
        input  data_from_ctrl,
        input  Adr_register_to_A,
        input  Adr_register_to_B,
        input  clear_req,
        output data_to_A,
        output data_to_B,
        output busy,
        output wr_err
    );
endinterface

// File: rtl/param_reg_file.sv
// Two-read/one-write register file with x0 hardwired to zero and
// a sequential clear that walks every address after reset.
module param_reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input logic            clk,
    input logic            rst,
    param_reg_file_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_n;
    logic              wr_err;
    logic              wr_err_n;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              busy;
    logic              wr_ok;

    assign busy  = (state == CLEAR);
    assign wr_ok = !busy && bus.write &&
                   (bus.Adr_register_to_save != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CLEAR;
            cnt    <= '0;
            wr_err <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            wr_err <= wr_err_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        wr_err_n = 1'b0;
        unique case (state)
            CLEAR: begin
                wr_err_n = bus.write;
                if (cnt == {ADDR_W{1'b1}}) begin
                    state_n = READY;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            READY: begin
                if (bus.clear_req) begin
                    state_n = CLEAR;
                    cnt_n   = '0;
                end
            end
            default: state_n = CLEAR;
        endcase
    end

    // Clearing and writing are mutually exclusive by state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy) begin
                regs[cnt] <= '0;
            end else if (wr_ok) begin
                regs[bus.Adr_register_to_save] <= bus.data_from_ctrl;
            end
        end
    end

    always_comb begin
        rd_a = regs[bus.Adr_register_to_A];
        if (rst || busy || bus.Adr_register_to_A == '0) begin
            rd_a = '0;
        end else if (BYPASS != 0 && wr_ok &&
                     bus.Adr_register_to_A ==
                     bus.Adr_register_to_save) begin
            rd_a = bus.data_from_ctrl;
        end
    end

    always_comb begin
        rd_b = regs[bus.Adr_register_to_B];
        if (rst || busy || bus.Adr_register_to_B == '0) begin
            rd_b = '0;
        end else if (BYPASS != 0 && wr_ok &&
                     bus.Adr_register_to_B ==
                     bus.Adr_register_to_save) begin
            rd_b = bus.data_from_ctrl;
        end
    end

    assign bus.data_to_A = rd_a;
    assign bus.data_to_B = rd_b;
    assign bus.busy      = busy;
    assign bus.wr_err    = wr_err;
endmodule

// File: tb/tb_param_reg_file.sv
// Directed bench: default config with and without bypass,
// plus a small 16x8 instance for the reset-restart case.
module tb_param_reg_file;
    logic clk = 1'b0;
    logic rst0;
    logic rst2;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    param_reg_file_if #(.DATA_W(32), .ADDR_W(5)) if0 ();
    param_reg_file_if #(.DATA_W(32), .ADDR_W(5)) if1 ();
    param_reg_file_if #(.DATA_W(16), .ADDR_W(3)) if2 ();

    assign if1.write                = if0.write;
    assign if1.Adr_register_to_save = if0.Adr_register_to_save;
    assign if1.data_from_ctrl       = if0.data_from_ctrl;
    assign if1.Adr_register_to_A    = if0.Adr_register_to_A;
    assign if1.Adr_register_to_B    = if0.Adr_register_to_B;
    assign if1.clear_req            = if0.clear_req;

    param_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut0 (
        .clk(clk), .rst(rst0), .bus(if0.slave));
    param_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut1 (
        .clk(clk), .rst(rst0), .bus(if1.slave));
    param_reg_file #(.DATA_W(16), .ADDR_W(3), .BYPASS(1)) dut2 (
        .clk(clk), .rst(rst2), .bus(if2.slave));

    typedef struct {
        logic        w;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] na;
        logic [31:0] nb;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int pulses;
        logic pw;

        vecs[0]  = '{1, 5, 555, 5, 3, 555, 0, 0, 0};
        vecs[1]  = '{1, 3, 333, 5, 3, 555, 333, 555, 0};
        vecs[2]  = '{0, 0, 0, 5, 3, 555, 333, 555, 333};
        vecs[3]  = '{1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 5, 0, 555, 0, 555};
        vecs[5]  = '{1, 7, 777, 7, 7, 777, 777, 0, 0};
        vecs[6]  = '{0, 0, 0, 7, 3, 777, 333, 777, 333};
        vecs[7]  = '{1, 5, 32'h12345678, 5, 5,
                     32'h12345678, 32'h12345678, 555, 555};
        vecs[8]  = '{0, 0, 0, 5, 7,
                     32'h12345678, 777, 32'h12345678, 777};
        vecs[9]  = '{1, 5, 555, 5, 5,
                     555, 555, 32'h12345678, 32'h12345678};
        vecs[10] = '{0, 0, 0, 5, 5, 555, 555, 555, 555};

        rst0 = 1'b1;
        rst2 = 1'b1;
        if0.write = 1'b0;
        if0.Adr_register_to_save = '0;
        if0.data_from_ctrl = '0;
        if0.Adr_register_to_A = '0;
        if0.Adr_register_to_B = '0;
        if0.clear_req = 1'b0;
        if2.write = 1'b0;
        if2.Adr_register_to_save = '0;
        if2.data_from_ctrl = '0;
        if2.Adr_register_to_A = 3'd7;
        if2.Adr_register_to_B = 3'd6;
        if2.clear_req = 1'b0;

        // Small instance: reset in the middle of the clear walk.
        step();
        step();
        rst2 = 1'b0;
        repeat (4) step();
        chk("s_busy_mid", if2.busy, 1);
        rst2 = 1'b1;
        step();
        chk("s_busy_rst", if2.busy, 1);
        chk("s_rd_rst", if2.data_to_A, 0);
        rst2 = 1'b0;
        n = 0;
        while (if2.busy && n < 100) begin
            step();
            n++;
        end
        chk("s_busy_len", n, 8);
        if2.write = 1'b1;
        if2.Adr_register_to_save = 3'd7;
        if2.data_from_ctrl = 16'hFFFF;
        #1;
        chk("s_byp", if2.data_to_A, 16'hFFFF);
        step();
        if2.write = 1'b0;
        #1;
        chk("s_rd7", if2.data_to_A, 16'hFFFF);
        chk("s_rd6", if2.data_to_B, 0);

        // Main instances: reset, write during rst, clear walk.
        if0.write = 1'b1;
        if0.Adr_register_to_save = 5'd5;
        if0.data_from_ctrl = 32'hAAAA;
        if0.Adr_register_to_A = 5'd5;
        step();
        step();
        chk("rst_busy", if0.busy, 1);
        chk("rst_err", if0.wr_err, 0);
        chk("rst_rd", if0.data_to_A, 0);
        if0.write = 1'b0;
        rst0 = 1'b0;
        n = 0;
        while (if0.busy && n < 100) begin
            step();
            n++;
        end
        chk("clr_len", n, 32);
        chk("clr_len_nb", if1.busy, 0);
        for (int a = 0; a < 32; a++) begin
            if0.Adr_register_to_A = a[4:0];
            if0.Adr_register_to_B = a[4:0];
            #1;
            chk("clr_rd_a", if0.data_to_A, 0);
            chk("clr_rd_b", if1.data_to_B, 0);
        end

        foreach (vecs[i]) begin
            if0.write = vecs[i].w;
            if0.Adr_register_to_save = vecs[i].wa;
            if0.data_from_ctrl = vecs[i].wd;
            if0.Adr_register_to_A = vecs[i].ra;
            if0.Adr_register_to_B = vecs[i].rb;
            #1;
            chk($sformatf("v%0d_a", i), if0.data_to_A, vecs[i].ea);
            chk($sformatf("v%0d_b", i), if0.data_to_B, vecs[i].eb);
            chk($sformatf("v%0d_na", i), if1.data_to_A, vecs[i].na);
            chk($sformatf("v%0d_nb", i), if1.data_to_B, vecs[i].nb);
            step();
            chk($sformatf("v%0d_err", i), if0.wr_err, 0);
        end

        // Clear request with a same-edge write, then busy writes.
        if0.write = 1'b1;
        if0.Adr_register_to_save = 5'd9;
        if0.data_from_ctrl = 32'd99;
        if0.clear_req = 1'b1;
        step();
        if0.write = 1'b0;
        if0.clear_req = 1'b0;
        chk("cr_busy", if0.busy, 1);
        chk("cr_err", if0.wr_err, 0);
        n = 0;
        pulses = 0;
        while (if0.busy && n < 100) begin
            if0.write = (n == 2 || n == 10);
            if0.clear_req = (n == 5);
            pw = if0.write;
            step();
            n++;
            if (if0.wr_err) pulses++;
            chk("cr_wr_err", if0.wr_err, pw);
        end
        if0.write = 1'b0;
        if0.clear_req = 1'b0;
        chk("cr_len", n, 32);
        chk("cr_pulses", pulses, 2);
        if0.Adr_register_to_A = 5'd5;
        if0.Adr_register_to_B = 5'd9;
        #1;
        chk("cr_rd5", if0.data_to_A, 0);
        chk("cr_rd9", if0.data_to_B, 0);
        chk("cr_rd5_nb", if1.data_to_A, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
